// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter: the run-time shift mode encoding.
package shifter_pkg;
  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_mode_t;
endpackage

// File: rtl/barrel_shift_stage.sv
// One combinational log2 stage: shifts by DIST when en is set, else passes through.
// Rotate is built only with PIPELINED_BARREL_SHIFTER_ROTATE_EN; otherwise ROR acts as LSR.
module barrel_shift_stage
  import shifter_pkg::*;
#(
  parameter int N    = 8,
  parameter int DIST = 1
) (
  input  logic [N-1:0] din,
  input  logic [1:0]   mode,
  input  logic         sign,
  input  logic         en,
  output logic [N-1:0] dout
);

  always_comb begin
    dout = din;
    if (en) begin
      case (shift_mode_t'(mode))
        SH_LSL:  dout = din << DIST;
        SH_LSR:  dout = din >> DIST;
        // Fill comes from the sign captured at input, not from din[N-1]
        SH_ASR:  dout = {{DIST{sign}}, din[N-1:DIST]};
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
        SH_ROR:  dout = {din[DIST-1:0], din[N-1:DIST]};
`else
        SH_ROR:  dout = din >> DIST;
`endif
        default: dout = din;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter_of_n.sv
// Pipelined variable shifter: SW registered log2 stages with a global-stall valid/ready
// handshake. Optional rotate via PIPELINED_BARREL_SHIFTER_ROTATE_EN.
module pipelined_barrel_shifter_of_n
  import shifter_pkg::*;
#(
  parameter  int N  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [SW-1:0] up_shift,
  input  logic [1:0]    up_mode,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data
);

  logic                   advance;
  logic [SW-1:0]          vld_pipe_q, vld_pipe_d;
  logic [SW-1:0][N-1:0]   data_q, data_d, stg_in, stg_out;
  logic [SW-1:0][SW-1:0]  shamt_q, shamt_d, shamt_in;
  logic [SW-1:0][1:0]     mode_q, mode_d, mode_in;
  logic [SW-1:0]          sign_q, sign_d, sign_in;

  // Shift bits are consumed LSB-first: each stage tests bit 0, then drops it.
  for (genvar k = 0; k < SW; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stg_in[k]   = up_data;
      assign shamt_in[k] = up_shift;
      assign mode_in[k]  = up_mode;
      assign sign_in[k]  = up_data[N-1];
    end else begin : g_body
      assign stg_in[k]   = data_q[k-1];
      assign shamt_in[k] = shamt_q[k-1];
      assign mode_in[k]  = mode_q[k-1];
      assign sign_in[k]  = sign_q[k-1];
    end

    barrel_shift_stage #(
      .N    (N),
      .DIST (1 << k)
    ) u_stage (
      .din  (stg_in[k]),
      .mode (mode_in[k]),
      .sign (sign_in[k]),
      .en   (shamt_in[k][0]),
      .dout (stg_out[k])
    );
  end

  assign down_valid = vld_pipe_q[SW-1];
  assign down_data  = data_q[SW-1];
  assign advance    = down_ready || !down_valid;
  assign up_ready   = advance;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    data_d     = data_q;
    shamt_d    = shamt_q;
    mode_d     = mode_q;
    sign_d     = sign_q;
    if (advance) begin
      vld_pipe_d = (vld_pipe_q << 1) | SW'(up_valid);
      data_d     = stg_out;
      mode_d     = mode_in;
      sign_d     = sign_in;
      for (int k = 0; k < SW; k++) shamt_d[k] = shamt_in[k] >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      data_q     <= '0;
      shamt_q    <= '0;
      mode_q     <= '0;
      sign_q     <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      data_q     <= data_d;
      shamt_q    <= shamt_d;
      mode_q     <= mode_d;
      sign_q     <= sign_d;
    end
  end

  // Last stage's side-band has no consumer.
  logic unused_meta;
  assign unused_meta = ^{shamt_q[SW-1], mode_q[SW-1], sign_q[SW-1]};

endmodule

// File: tb/tb_pipelined_barrel_shifter_of_n.sv
// Scoreboard bench for pipelined_barrel_shifter_of_n (N=8): directed vectors,
// stall/hold, reset-in-flight and random traffic against an arithmetic model.
module tb_pipelined_barrel_shifter_of_n;
  localparam int N  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst, up_valid, up_ready, down_valid, down_ready;
  logic [N-1:0]  up_data, down_data;
  logic [SW-1:0] up_shift;
  logic [1:0]    up_mode;

  int          vectors = 0, miscompares = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  cur_exp = 8'h00;
  logic        xfer_seen = 1'b0, prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic        bp_done;

  pipelined_barrel_shifter_of_n #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .up_shift(up_shift), .up_mode(up_mode),
    .down_valid(down_valid), .down_ready(down_ready), .down_data(down_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on the operand value.
  function automatic logic [7:0] ref_shift(input logic [7:0] a, input int s, input int m);
    int v;
    case (m)
      0: return 8'((int'(a) * (1 << s)) % 256);
      1: return 8'(int'(a) / (1 << s));
      2: begin
        v = a[7] ? int'(a) - 256 : int'(a);
        v = (v >= 0) ? v / (1 << s) : -((-v + (1 << s) - 1) / (1 << s));
        return 8'(v);
      end
      default: begin
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
        return 8'((int'(a) * 257) / (1 << s));
`else
        return 8'(int'(a) / (1 << s));
`endif
      end
    endcase
  endfunction

  // Monitor/scoreboard: sample mid-cycle, acting on the transfers of the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
      xfer_seen  = 1'b0;
    end else begin
      check("up_ready", 8'(up_ready), 8'(down_ready || !down_valid));
      if (prev_stall) begin
        check("hold_valid", 8'(down_valid), 8'd1);
        check("hold_data", down_data, prev_data);
      end
      if (down_valid && down_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: got %h, expected no item", down_data);
        end else begin
          check("down_data", down_data, exp_q.pop_front());
        end
      end
      prev_stall = down_valid && !down_ready;
      prev_data  = down_data;
      xfer_seen  = up_valid && up_ready;
      if (xfer_seen) exp_q.push_back(cur_exp);
    end
  end

  // Call at posedge+1; returns at posedge+1 after the item is accepted.
  task automatic issue(input logic [7:0] a, input logic [2:0] s, input logic [1:0] m,
                       input logic [7:0] e);
    logic ok;
    up_data  = a;
    up_shift = s;
    up_mode  = m;
    cur_exp  = e;
    up_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(posedge clk);
      ok = xfer_seen;
    end
    #1 up_valid = 1'b0;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got no up transfer, expected one within 64 cycles");
    end
  endtask

  task automatic issue_rand();
    logic [7:0] a;
    int s, m;
    a = 8'($urandom);
    s = $urandom_range(0, 7);
    m = $urandom_range(0, 3);
    issue(a, 3'(s), 2'(m), ref_shift(a, s, m));
  endtask

  initial begin
    rst = 1'b1; up_valid = 1'b0; down_ready = 1'b1;
    up_data = '0; up_shift = '0; up_mode = '0; bp_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_up_ready", 8'(up_ready), 8'd1);
    check("rst_down_valid", 8'(down_valid), 8'd0);
    check("rst_down_data", down_data, 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_down_valid", 8'(down_valid), 8'd0);

    // Directed vectors with hand-derived results
    issue(8'h81, 3'd3, 2'b00, 8'h08);
    issue(8'hA0, 3'd2, 2'b10, 8'hE8);
    issue(8'hA0, 3'd2, 2'b01, 8'h28);
    for (int m = 0; m < 4; m++) issue(8'hA0, 3'd0, 2'(m), 8'hA0);
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
    issue(8'h03, 3'd1, 2'b11, 8'h81);
`else
    issue(8'h03, 3'd1, 2'b11, 8'h01);
`endif
    issue(8'h7F, 3'd7, 2'b10, 8'h00);
    issue(8'h80, 3'd7, 2'b10, 8'hFF);
    repeat (5) @(posedge clk); #1;

    // Stream of 8 with a 4-cycle consumer stall starting around item 2
    fork
      begin
        for (int i = 0; i < 8; i++) issue_rand();
      end
      begin
        repeat (3) @(posedge clk);
        #1 down_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 down_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk); #1;

    // Reset with three items in flight: none may emerge
    for (int i = 0; i < 3; i++) issue_rand();
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_down_valid", 8'(down_valid), 8'd0);
    check("midrst_down_data", down_data, 8'h00);
    check("midrst_up_ready", 8'(up_ready), 8'd1);
    rst = 1'b0;
    repeat (8) @(posedge clk); #1;

    // Random traffic under random backpressure
    fork
      begin
        for (int i = 0; i < 200; i++) issue_rand();
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk);
          #1 down_ready = ($urandom_range(0, 3) != 0);
        end
        down_ready = 1'b1;
      end
    join

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d items outstanding, expected 0", exp_q.size());
    end
    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
